// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped UART transmitter with TX FIFO
//
// Purpose: the CPU pushes bytes into a small TX FIFO through a bus slave port.
// A baud-rate FSM serialises each byte LSB first on txOutput (8N1, or 8E1/8O1
// when UART_TX_PARITY_EN is defined).
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   bSel      slave select from the bus decoder
//   bWrite    write strobe, qualified by bSel
//   bAddress  bus address, only [3:2] decoded
//               0 TXDATA (W)  1 STATUS/CTRL (R/W)  2 BAUDDIV (R/W)  3 reserved
//   bWData    write data
//   bRData    read data, combinational from address and registers
//   txOutput  serial line, idle high, driven from a flop
//   txIrq     high while the FIFO is empty and the FSM is idle (registered)
//
// Optional feature macro: UART_TX_PARITY_EN (adds a PARITY bit, STATUS[8] = odd select)

module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] BAUDDIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bSel,
  input  logic        bWrite,
  input  logic [31:0] bAddress,
  input  logic [31:0] bWData,
  output logic [31:0] bRData,
  output logic        txOutput,
  output logic        txIrq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_baud;
  state_t        r_state;
  logic [7:0]    r_shreg;
  logic [2:0]    r_idx;
  logic [15:0]   r_baud_cnt;
  logic          r_tx;
  logic          r_irq;
`ifdef UART_TX_PARITY_EN
  logic          r_odd;
  logic          r_par;
`endif

  logic [1:0]    w_addr;
  logic          w_wr;
  logic          w_wr_data;
  logic          w_wr_stat;
  logic          w_wr_baud;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_bit_end;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count_next;
  state_t        w_state_next;
  logic [7:0]    w_shreg_next;
  logic [2:0]    w_idx_next;
  logic [15:0]   w_cnt_next;
  logic          w_tx_next;
  logic [31:0]   w_status;
  logic          w_unused_bits;

  assign w_addr    = bAddress[3:2];
  assign w_wr      = bSel && bWrite;
  assign w_wr_data = w_wr && (w_addr == 2'd0);
  assign w_wr_stat = w_wr && (w_addr == 2'd1);
  assign w_wr_baud = w_wr && (w_addr == 2'd2);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_head    = r_mem[r_rptr];
  assign w_bit_end = (r_baud_cnt == 16'd0);

  // Pops only happen from IDLE, so a push into an empty FIFO is seen one cycle later.
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  // Fullness is judged before this cycle's pop: a simultaneous pop frees the slot.
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_ovf_set = w_wr_data && w_full && !w_pop;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  assign w_unused_bits = ^{bAddress[31:4], bAddress[1:0], bWData[31:16]};

  // Baud counter is reloaded from r_baud only at bit boundaries, so a BAUDDIV
  // write never stretches or shortens the bit currently on the line.
  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_idx_next   = r_idx;
    w_cnt_next   = r_baud_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = S_START;
          w_shreg_next = w_head;
          w_cnt_next   = r_baud;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_idx_next   = 3'd0;
          w_cnt_next   = r_baud;
        end else begin
          w_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = r_baud;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_shreg_next = {1'b0, r_shreg[7:1]};
          end
        end else begin
          w_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_cnt_next   = r_baud;
        end else begin
          w_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the flop changes on the same
  // edge as the FSM, keeping txOutput glitch-free and aligned to the state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shreg_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_par;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    w_status      = 32'd0;
    w_status[0]   = w_empty;
    w_status[1]   = w_full;
    w_status[2]   = (r_state != S_IDLE);
    w_status[3]   = r_ovf;
    w_status[7:4] = 4'(r_count);
`ifdef UART_TX_PARITY_EN
    w_status[8]   = r_odd;
`endif
  end

  always_comb begin
    bRData = 32'd0;
    case (w_addr)
      2'd1:    bRData = w_status;
      2'd2:    bRData = {16'd0, r_baud};
      default: bRData = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bWData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_baud     <= BAUDDIV_RST;
      r_state    <= S_IDLE;
      r_shreg    <= 8'd0;
      r_idx      <= 3'd0;
      r_baud_cnt <= 16'd0;
      r_tx       <= 1'b1;
      r_irq      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_odd      <= 1'b0;
      r_par      <= 1'b0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_next;
      if (w_wr_stat)      r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      if (w_wr_baud) begin
        r_baud <= (bWData[15:0] == 16'd0) ? 16'd1 : bWData[15:0];
      end
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_idx      <= w_idx_next;
      r_baud_cnt <= w_cnt_next;
      r_tx       <= w_tx_next;
      r_irq      <= (w_count_next == '0) && (w_state_next == S_IDLE);
`ifdef UART_TX_PARITY_EN
      if (w_wr_stat) r_odd <= bWData[8];
      // Parity is fixed at pop time from the byte and the current odd/even select.
      if (w_pop)     r_par <= (^w_head) ^ r_odd;
`endif
    end
  end

  assign txOutput = r_tx;
  assign txIrq    = r_irq;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - directed self-checking bench for uart_tx_periph

module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        rst;
  logic        bSel;
  logic        bWrite;
  logic [31:0] bAddress;
  logic [31:0] bWData;
  logic [31:0] bRData;
  logic        txOutput;
  logic        txIrq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 11 : 10;

  uart_tx_periph #(.FIFO_DEPTH(4), .BAUDDIV_RST(16'd434)) dut (
    .clk(clk), .rst(rst), .bSel(bSel), .bWrite(bWrite), .bAddress(bAddress),
    .bWData(bWData), .bRData(bRData), .txOutput(txOutput), .txIrq(txIrq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bSel = 1'b1; bWrite = 1'b1; bAddress = a; bWData = d;
    @(posedge clk);
    #1;
    bSel = 1'b0; bWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bSel = 1'b1; bWrite = 1'b0; bAddress = a;
    #1;
    d = bRData;
    bSel = 1'b0;
  endtask

  // Expected line level k cycles after the pop edge (k=1 is the first START cycle).
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int p,
                                   input logic pb);
    int seg;
    seg = (k - 1) / p;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return d[seg-1];
    if (PAR_EN && seg == 9) return pb;
    return 1'b1;
  endfunction

  task automatic rx_capture(input int p, output logic [7:0] b, output int sc,
                            output bit ok, output logic stop_v);
    ok = 1'b0; b = 8'h00; sc = 0; stop_v = 1'bx;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (txOutput === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    sc = cyc;
    step(p / 2);
    for (int j = 0; j < 8; j++) begin
      step(p);
      b[j] = txOutput;
    end
    if (PAR_EN) step(p);
    step(p);
    stop_v = txOutput;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; bSel = 1'b0; bWrite = 1'b0; bAddress = 32'd0; bWData = 32'd0;
    step(3);
    total++; if (txOutput !== 1'b1) begin bad++; $display("FAIL reset_tx act=%b exp=1", txOutput); end
    total++; if (txIrq !== 1'b1) begin bad++; $display("FAIL reset_irq act=%b exp=1", txIrq); end
    rst = 1'b0;
    step(1);
    bus_read(32'h4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_status act=%h exp=1", d); end
    bus_read(32'h8, d);
    total++; if (d !== 32'd434) begin bad++; $display("FAIL reset_baud act=%0d exp=434", d); end
    bus_read(32'h0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read act=%h exp=0", d); end
    step(1);
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_read act=%h exp=0", d); end
    bus_read(32'h8, d);
    total++; if (d !== 32'd434) begin bad++; $display("FAIL reserved_wr_baud act=%0d exp=434", d); end
    bus_read(32'h4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL reserved_wr_status act=%h exp=1", d); end
  endtask

  task automatic test_frame;
    logic [31:0] d;
    logic        e;
    bus_write(32'h8, 32'd3);
    bus_read(32'h8, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL baud3_read act=%0d exp=3", d); end
    bus_write(32'h0, 32'hA5);
    total++; if (txOutput !== 1'b1) begin bad++; $display("FAIL frame_pre_tx act=%b exp=1", txOutput); end
    total++; if (txIrq !== 1'b0) begin bad++; $display("FAIL frame_irq_fall act=%b exp=0", txIrq); end
    for (int k = 1; k <= NBITS * 4; k++) begin
      step(1);
      e = exp_bit(k, 8'hA5, 4, ^8'hA5);
      total++; if (txOutput !== e) begin bad++; $display("FAIL frame_bit k=%0d act=%b exp=%b", k, txOutput, e); end
      if (k == 20) begin
        bus_read(32'h4, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL frame_busy act=%h exp=5", d); end
      end
    end
    step(1);
    total++; if (txIrq !== 1'b1) begin bad++; $display("FAIL frame_irq_end act=%b exp=1", txIrq); end
    bus_read(32'h4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL frame_idle_status act=%h exp=1", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [6];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h77;
    fork
      begin
        logic [31:0] d;
        int t0;
        bus_write(32'h0, 32'h11);
        t0 = cyc;
        bus_write(32'h0, 32'h22);
        bus_write(32'h0, 32'h33);
        bus_write(32'h0, 32'h44);
        bus_write(32'h0, 32'h55);
        bus_read(32'h4, d);
        total++; if (d !== 32'h46) begin bad++; $display("FAIL b2b_full act=%h exp=46", d); end
        bus_write(32'h0, 32'h66);
        bus_read(32'h4, d);
        total++; if (d !== 32'h4E) begin bad++; $display("FAIL b2b_overflow act=%h exp=4e", d); end
        bus_write(32'h4, 32'h0);
        bus_read(32'h4, d);
        total++; if (d !== 32'h46) begin bad++; $display("FAIL b2b_ovf_clear act=%h exp=46", d); end
        while (cyc < t0 + NBITS * 4 + 1) step(1);
        bus_read(32'h4, d);
        total++; if (d !== 32'h42) begin bad++; $display("FAIL b2b_idle_full act=%h exp=42", d); end
        bus_write(32'h0, 32'h77);
        bus_read(32'h4, d);
        total++; if (d !== 32'h46) begin bad++; $display("FAIL b2b_push_on_pop act=%h exp=46", d); end
      end
      begin
        logic [7:0] b;
        int sc;
        int prev;
        bit ok;
        logic sv;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
          rx_capture(4, b, sc, ok, sv);
          total++;
          if (!ok) begin
            bad++; $display("FAIL b2b_rx_timeout idx=%0d act=none exp=start", i);
          end else if (b !== exp_b[i]) begin
            bad++; $display("FAIL b2b_rx_byte idx=%0d act=%h exp=%h", i, b, exp_b[i]);
          end
          total++; if (sv !== 1'b1) begin bad++; $display("FAIL b2b_rx_stop idx=%0d act=%b exp=1", i, sv); end
          if (i > 0) begin
            total++;
            if (sc - prev != NBITS * 4 + 1) begin
              bad++; $display("FAIL b2b_gap idx=%0d act=%0d exp=%0d", i, sc - prev, NBITS * 4 + 1);
            end
          end
          prev = sc;
        end
      end
    join
  endtask

  task automatic test_baud;
    logic [31:0] d;
    logic        eq[$];
    bit          ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (txIrq === 1'b1) begin ok = 1'b1; break; end
      step(1);
    end
    total++; if (!ok) begin bad++; $display("FAIL baud_wait_idle act=%b exp=1", txIrq); end
    step(2);
    bus_write(32'h8, 32'd0);
    bus_read(32'h8, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL baud_zero act=%0d exp=1", d); end
    repeat (2) eq.push_back(1'b0);
    for (int j = 0; j < 3; j++) repeat (2) eq.push_back(8'h55 >> j & 8'h01 ? 1'b1 : 1'b0);
    for (int j = 3; j < 8; j++) repeat (8) eq.push_back(8'h55 >> j & 8'h01 ? 1'b1 : 1'b0);
    if (PAR_EN) repeat (8) eq.push_back(1'b0);
    repeat (8) eq.push_back(1'b1);
    bus_write(32'h0, 32'h55);
    for (int k = 1; k <= eq.size(); k++) begin
      if (k == 7) begin
        bSel = 1'b1; bWrite = 1'b1; bAddress = 32'h8; bWData = 32'd7;
      end
      @(posedge clk);
      #1;
      bSel = 1'b0; bWrite = 1'b0;
      total++; if (txOutput !== eq[k-1]) begin bad++; $display("FAIL baud_mid k=%0d act=%b exp=%b", k, txOutput, eq[k-1]); end
    end
    step(1);
    total++; if (txIrq !== 1'b1) begin bad++; $display("FAIL baud_irq_end act=%b exp=1", txIrq); end
    bus_read(32'h8, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL baud7_read act=%0d exp=7", d); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    bus_write(32'h8, 32'd3);
    bus_write(32'h0, 32'h00);
    bus_write(32'h0, 32'h5A);
    step(21);
    total++; if (txOutput !== 1'b0) begin bad++; $display("FAIL rstmid_pre act=%b exp=0", txOutput); end
    rst = 1'b1;
    step(1);
    total++; if (txOutput !== 1'b1) begin bad++; $display("FAIL rstmid_tx act=%b exp=1", txOutput); end
    total++; if (txIrq !== 1'b1) begin bad++; $display("FAIL rstmid_irq act=%b exp=1", txIrq); end
    bus_read(32'h4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL rstmid_status act=%h exp=1", d); end
    bus_read(32'h8, d);
    total++; if (d !== 32'd434) begin bad++; $display("FAIL rstmid_baud act=%0d exp=434", d); end
    rst = 1'b0;
    step(4);
    total++; if (txOutput !== 1'b1) begin bad++; $display("FAIL rstmid_quiet act=%b exp=1", txOutput); end
    bus_read(32'h4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL rstmid_after act=%h exp=1", d); end
  endtask

  task automatic test_parity;
    logic [31:0] d;
    logic        e;
    bus_write(32'h8, 32'd3);
    bus_write(32'h4, 32'h100);
    bus_read(32'h4, d);
    total++; if (d !== (PAR_EN ? 32'h101 : 32'h1)) begin bad++; $display("FAIL par_odd_sel act=%h exp=%h", d, PAR_EN ? 32'h101 : 32'h1); end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        bus_write(32'h4, 32'h0);
        bus_read(32'h4, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL par_even_sel act=%h exp=1", d); end
      end
      bus_write(32'h0, 32'h03);
      for (int k = 1; k <= NBITS * 4; k++) begin
        step(1);
        e = exp_bit(k, 8'h03, 4, (pass == 0) ? 1'b1 : 1'b0);
        total++; if (txOutput !== e) begin bad++; $display("FAIL par_frame pass=%0d k=%0d act=%b exp=%b", pass, k, txOutput, e); end
      end
      step(1);
      total++; if (txIrq !== 1'b1) begin bad++; $display("FAIL par_irq pass=%0d act=%b exp=1", pass, txIrq); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_baud();
    test_reset_midframe();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
